// File: rtl/udp_tx.sv
// UDP transmit engine: checksums a payload held in an external byte RAM, then streams
// the 8-byte UDP header and the payload to IP TX, one byte per clock.
module udp_tx #(
  parameter logic [15:0] SRC_PORT = 16'h1F90,
  parameter logic [15:0] DST_PORT = 16'h1F90,
  parameter int          MAX_LEN  = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        udp_send_req,
  input  logic [15:0] udp_send_data_length,
  input  logic [31:0] ip_send_source_addr,
  input  logic [31:0] ip_send_dest_addr,
  output logic [10:0] udp_ram_read_addr,
  input  logic [7:0]  udp_ram_rdata,
  output logic        udp_tx_req,
  output logic [15:0] udp_tx_length,
  input  logic        ip_tx_ack,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        udp_tx_end,
  output logic        udp_busy,
  output logic        udp_send_done
);

  typedef enum logic [2:0] {
    IDLE, SUM_DATA, SUM_FOLD, WAIT_ACK, SEND_HEAD, SEND_DATA, DONE
  } state_t;

  state_t      state_q;
  logic [31:0] sum_q;
  logic [15:0] csum_q, tx_len_q;
  logic [10:0] last_q, cnt_q, addr_q;
  logic [7:0]  hi_q, data_q;
  logic        iss_q, rvld_q;
  logic        tx_req_q, valid_q, end_q, busy_q, done_q;

  logic [15:0] len8_d, word_d;
  logic [31:0] pseudo_d;
  logic        accept_d;

  // Two end-around folds of the 32-bit sum, one's complement, zero sent as FFFF.
  function automatic logic [15:0] sum_to_csum(input logic [31:0] s);
    logic [31:0] t;
    logic [15:0] c;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
    c = ~t[15:0];
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] len8,
                                          input logic [15:0] cs);
    case (idx)
      3'd0:    return SRC_PORT[15:8];
      3'd1:    return SRC_PORT[7:0];
      3'd2:    return DST_PORT[15:8];
      3'd3:    return DST_PORT[7:0];
      3'd4:    return len8[15:8];
      3'd5:    return len8[7:0];
      3'd6:    return cs[15:8];
      default: return cs[7:0];
    endcase
  endfunction

  always_comb begin
    len8_d   = udp_send_data_length + 16'd8;
    accept_d = udp_send_req && (udp_send_data_length != 16'd0) &&
               (udp_send_data_length <= 16'(MAX_LEN));
    pseudo_d = {16'h0, ip_send_source_addr[31:16]} + {16'h0, ip_send_source_addr[15:0]} +
               {16'h0, ip_send_dest_addr[31:16]} + {16'h0, ip_send_dest_addr[15:0]} +
               32'h0000_0011 + {15'h0, len8_d, 1'b0} +
               {16'h0, SRC_PORT} + {16'h0, DST_PORT};
    // Odd byte index closes a big-endian pair; an even last byte is padded low.
    word_d   = cnt_q[0] ? {hi_q, udp_ram_rdata} : {udp_ram_rdata, 8'h00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sum_q    <= '0;
      csum_q   <= '0;
      tx_len_q <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      hi_q     <= '0;
      data_q   <= '0;
      iss_q    <= 1'b0;
      rvld_q   <= 1'b0;
      tx_req_q <= 1'b0;
      valid_q  <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sum_q  <= '0;
          cnt_q  <= '0;
          addr_q <= '0;
          iss_q  <= 1'b0;
          rvld_q <= 1'b0;
          if (accept_d) begin
            state_q  <= SUM_DATA;
            sum_q    <= pseudo_d;
            tx_len_q <= len8_d;
            last_q   <= udp_send_data_length[10:0] - 11'd1;
            iss_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SUM_DATA: begin
          // rvld_q marks that rdata answers the address shown in the previous cycle.
          rvld_q <= iss_q;
          if (iss_q) begin
            if (addr_q == last_q) iss_q <= 1'b0;
            else                  addr_q <= addr_q + 11'd1;
          end
          if (rvld_q) begin
            if (!cnt_q[0]) hi_q <= udp_ram_rdata;
            if (cnt_q[0] || cnt_q == last_q) sum_q <= sum_q + {16'h0, word_d};
            cnt_q <= cnt_q + 11'd1;
            if (cnt_q == last_q) state_q <= SUM_FOLD;
          end
        end
        SUM_FOLD: begin
          csum_q   <= sum_to_csum(sum_q);
          state_q  <= WAIT_ACK;
          tx_req_q <= 1'b1;
          cnt_q    <= '0;
          addr_q   <= '0;
        end
        WAIT_ACK: begin
          if (ip_tx_ack) begin
            state_q  <= SEND_HEAD;
            tx_req_q <= 1'b0;
            data_q   <= hdr_byte(3'd0, tx_len_q, csum_q);
            valid_q  <= 1'b1;
          end
        end
        SEND_HEAD: begin
          // Payload reads start two bytes before the header ends to hide RAM latency.
          if (cnt_q == 11'd5)       addr_q <= '0;
          else if (cnt_q >= 11'd6)  addr_q <= addr_q + 11'd1;
          if (cnt_q == 11'd7) begin
            state_q <= SEND_DATA;
            data_q  <= udp_ram_rdata;
            end_q   <= (last_q == 11'd0);
            cnt_q   <= '0;
          end else begin
            data_q <= hdr_byte(cnt_q[2:0] + 3'd1, tx_len_q, csum_q);
            cnt_q  <= cnt_q + 11'd1;
          end
        end
        SEND_DATA: begin
          if (cnt_q == last_q) begin
            state_q <= DONE;
            data_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            data_q <= udp_ram_rdata;
            end_q  <= (cnt_q + 11'd1 == last_q);
            cnt_q  <= cnt_q + 11'd1;
            addr_q <= addr_q + 11'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign udp_ram_read_addr = addr_q;
  assign udp_tx_req        = tx_req_q;
  assign udp_tx_length     = tx_len_q;
  assign udp_tx_data       = data_q;
  assign udp_tx_valid      = valid_q;
  assign udp_tx_end        = end_q;
  assign udp_busy          = busy_q;
  assign udp_send_done     = done_q;

endmodule

// File: tb/tb_udp_tx.sv
// Bench for udp_tx: fixed vectors, hand-written corner sequences and random frames,
// all checked against a byte-level checksum/stream model of the UDP framing rules.
module tb_udp_tx;
  localparam logic [15:0] SP   = 16'h1F90;
  localparam logic [15:0] DP   = 16'h1F90;
  localparam int          MAXL = 1472;

  logic        clk = 1'b0;
  logic        rst, req, ack;
  logic [15:0] dlen;
  logic [31:0] sip, dip;
  logic [10:0] raddr;
  logic [7:0]  rdata;
  logic        txreq, txv, txe, busy, done;
  logic [15:0] txlen;
  logic [7:0]  txd;

  udp_tx #(.SRC_PORT(SP), .DST_PORT(DP), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst(rst), .udp_send_req(req), .udp_send_data_length(dlen),
    .ip_send_source_addr(sip), .ip_send_dest_addr(dip), .udp_ram_read_addr(raddr),
    .udp_ram_rdata(rdata), .udp_tx_req(txreq), .udp_tx_length(txlen), .ip_tx_ack(ack),
    .udp_tx_data(txd), .udp_tx_valid(txv), .udp_tx_end(txe), .udp_busy(busy),
    .udp_send_done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) rdata <= mem[raddr];

  typedef struct {
    int          len;
    logic [31:0] src;
    logic [31:0] dst;
    int          ack_dly;
    int          pat;
    bit          use_const;
    logic [15:0] csum;
  } vec_t;

  vec_t vecs [7];
  int   errors, checks;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [39:0] outs();
    return {txreq, txv, txe, busy, done, txd, raddr, txlen};
  endfunction

  function automatic logic [31:0] pseudo_sum(input int len, input logic [31:0] s, input logic [31:0] d);
    return 32'(s[31:16]) + 32'(s[15:0]) + 32'(d[31:16]) + 32'(d[15:0]) + 32'd17 +
           32'(2 * (len + 8)) + 32'(SP) + 32'(DP);
  endfunction

  function automatic logic [15:0] ones_fold(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    while (x > 32'hFFFF) x = (x & 32'hFFFF) + (x >> 16);
    return x[15:0];
  endfunction

  function automatic logic [15:0] ref_csum(input int len, input logic [31:0] s, input logic [31:0] d);
    logic [31:0] acc;
    logic [15:0] c;
    acc = pseudo_sum(len, s, d);
    for (int k = 0; k < len; k += 2)
      acc += 32'({mem[k], (k + 1 < len) ? mem[k + 1] : 8'h00});
    c = ~ones_fold(acc);
    return (c == 16'h0000) ? 16'hFFFF : c;
  endfunction

  // pat 0: bytes 01,02,...; pat 1: random; pat 2: first word chosen so the folded sum is FFFF
  task automatic fill(input int pat, input int len, input logic [31:0] s, input logic [31:0] d);
    logic [15:0] w;
    for (int k = 0; k < 2048; k++) mem[k] = (pat == 0) ? 8'(k + 1) : 8'($urandom);
    if (pat == 2) begin
      w = ~ones_fold(pseudo_sum(len, s, d));
      mem[0] = w[15:8];
      mem[1] = w[7:0];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [31:0] s, input logic [31:0] d,
                           input int ack_dly, input bit use_const, input logic [15:0] cconst,
                           input int abort_at, input bit stray);
    logic [7:0]  exp_b [$];
    logic [15:0] ecs, gcs, len8;
    int          cyc, nbad, first_bad, nend, ends_seen;
    len8 = 16'(len + 8);
    ecs  = use_const ? cconst : ref_csum(len, s, d);
    gcs  = '0;
    exp_b = {};
    exp_b.push_back(SP[15:8]);   exp_b.push_back(SP[7:0]);
    exp_b.push_back(DP[15:8]);   exp_b.push_back(DP[7:0]);
    exp_b.push_back(len8[15:8]); exp_b.push_back(len8[7:0]);
    exp_b.push_back(ecs[15:8]);  exp_b.push_back(ecs[7:0]);
    for (int k = 0; k < len; k++) exp_b.push_back(mem[k]);

    @(negedge clk);
    req = 1'b1; dlen = 16'(len); sip = s; dip = d;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    if (stray) begin
      req = 1'b1; dlen = 16'd5;
      @(negedge clk);
      req = 1'b0; ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      cyc = 3;
      check("stray_ack_no_req", 64'(txreq), 64'd0);
    end
    while (!txreq && cyc <= len + 8) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("req_within_L+8 L=%0d", len), 64'(txreq), 64'd1);
    if (!txreq) begin
      do_reset();
      return;
    end
    check("tx_length", 64'(txlen), 64'(len8));
    repeat (ack_dly) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("req_drop_after_ack", 64'(txreq), 64'd0);

    nbad = 0; first_bad = -1; nend = 0; ends_seen = 0;
    for (int i = 0; i < len + 8; i++) begin
      if (!txv || txd !== exp_b[i]) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
      if (txe !== (i == len + 7)) nend++;
      if (txe) ends_seen++;
      if (i == 6) gcs[15:8] = txd;
      if (i == 7) gcs[7:0]  = txd;
      if (abort_at >= 0 && i == 8 + abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("outs_after_midframe_rst", 64'(outs()), 64'd0);
        check("no_end_before_abort", 64'(ends_seen), 64'd0);
        check("bytes_before_abort", 64'(nbad), 64'd0);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check($sformatf("stream L=%0d first_bad=%0d", len, first_bad), 64'(nbad), 64'd0);
    check($sformatf("end_marker L=%0d", len), 64'(nend), 64'd0);
    check($sformatf("checksum L=%0d", len), 64'(gcs), 64'(ecs));
    check("done_pulse", 64'({done, txv}), 64'b10);
    @(negedge clk);
    check("idle_after_done", 64'({busy, done}), 64'd0);
    if (stray) begin
      repeat (3) @(negedge clk);
      check("no_second_frame", 64'({busy, txreq}), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    logic [31:0] rs, rd;
    int rl;
    errors = 0; checks = 0;
    rst = 1'b1; req = 1'b0; ack = 1'b0; dlen = '0; sip = '0; dip = '0;
    fill(1, 0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(outs()), 64'd0);
    rst = 1'b0;

    vecs[0] = '{len: 4,    src: 32'hC0A8010A, dst: 32'hC0A80103, ack_dly: 3, pat: 0, use_const: 1'b1, csum: 16'h3952};
    vecs[1] = '{len: 3,    src: 32'hC0A8010A, dst: 32'hC0A80103, ack_dly: 3, pat: 0, use_const: 1'b1, csum: 16'h3958};
    vecs[2] = '{len: 1,    src: 32'h0A000001, dst: 32'h0A000002, ack_dly: 0, pat: 1, use_const: 1'b0, csum: 16'h0};
    vecs[3] = '{len: 1472, src: $urandom,     dst: $urandom,     ack_dly: 2, pat: 1, use_const: 1'b0, csum: 16'h0};
    vecs[4] = '{len: 2,    src: 32'hC0A8010A, dst: 32'hC0A80103, ack_dly: 1, pat: 2, use_const: 1'b1, csum: 16'hFFFF};
    vecs[5] = '{len: 2,    src: $urandom,     dst: $urandom,     ack_dly: 0, pat: 2, use_const: 1'b1, csum: 16'hFFFF};
    vecs[6] = '{len: 33,   src: $urandom,     dst: $urandom,     ack_dly: 4, pat: 1, use_const: 1'b0, csum: 16'h0};
    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].pat, vecs[i].len, vecs[i].src, vecs[i].dst);
      run_frame(vecs[i].len, vecs[i].src, vecs[i].dst, vecs[i].ack_dly,
                vecs[i].use_const, vecs[i].csum, -1, 1'b0);
    end

    // Illegal lengths must leave the block idle with no RAM reads.
    @(negedge clk);
    req = 1'b1; dlen = 16'd0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; dlen = 16'd1473;
    @(negedge clk);
    req = 1'b0;
    act = 0;
    repeat (5) begin
      if (busy || txreq || raddr != 11'd0) act++;
      @(negedge clk);
    end
    check("illegal_len_ignored", 64'(act), 64'd0);
    fill(1, 1, 32'h01020304, 32'h05060708);
    run_frame(1, 32'h01020304, 32'h05060708, 1, 1'b0, 16'h0, -1, 1'b0);

    // Second request and stray ack while busy.
    fill(1, 16, 32'hC0A80001, 32'hC0A80002);
    run_frame(16, 32'hC0A80001, 32'hC0A80002, 2, 1'b0, 16'h0, -1, 1'b1);

    // Reset during the 5th payload byte, then the same frame in full.
    fill(1, 64, 32'hAC100001, 32'hAC100002);
    run_frame(64, 32'hAC100001, 32'hAC100002, 1, 1'b0, 16'h0, 4, 1'b0);
    run_frame(64, 32'hAC100001, 32'hAC100002, 1, 1'b0, 16'h0, -1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      rl = $urandom_range(1, 120);
      rs = $urandom;
      rd = $urandom;
      fill(1, rl, rs, rd);
      run_frame(rl, rs, rd, $urandom_range(0, 4), 1'b0, 16'h0, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
